// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and constants for the shared-multiplier sequencing controller.
package mult_share_ctrl_pkg;

   // Controller FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_t;

   // Default slack added to the operand width to form the WAIT-state limit.
   localparam int TMO_OFFSET = 8;

   // Width of a counter that must be able to hold the value n.
   function automatic int count_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

   // Increment an index, wrapping back to zero after n entries.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or
// above ptr, wrapping to the lowest active request when none is found above.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   logic [NREQ-1:0] upper_mask;
   logic [NREQ-1:0] upper_req;
   logic [NREQ-1:0] sel_req;

   // Thermometer mask selecting requesters at or above the pointer.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_mask
         assign upper_mask[gi] = (gi >= int'(ptr));
      end
   endgenerate

   assign upper_req = req & upper_mask;
   // Fall back to the full vector when nothing sits at or above the pointer,
   // which gives the wrap-around search order.
   assign sel_req   = (|upper_req) ? upper_req : req;

   // Priority encode the lowest set bit of the selected vector.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (sel_req[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential multiplier between NREQ requesters: round-robin
// grant, operand capture, start pulse, ready wait with timeout, and a
// one-cycle done pulse back to the owning requester.
module mult_share_ctrl
   import mult_share_ctrl_pkg::*;
#(
   parameter int nb   = 32,
   parameter int NREQ = 4,
   parameter int TMO  = nb + TMO_OFFSET
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*nb-1:0]   a_in,
   input  logic [NREQ*nb-1:0]   b_in,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      done,
   output logic [2*nb-1:0]      result,
   output logic                 tmo,
   output logic                 busy,
   output logic                 mul_start,
   output logic [nb-1:0]        mul_a,
   output logic [nb-1:0]        mul_b,
   input  logic [2*nb-1:0]      mul_product,
   input  logic                 mul_ready
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = count_width(TMO);

   ctrl_state_t      state_reg;
   ctrl_state_t      state_next;
   logic [IW-1:0]    ptr_reg;
   logic [IW-1:0]    owner_reg;
   logic [nb-1:0]    a_reg;
   logic [nb-1:0]    b_reg;
   logic [CW-1:0]    cnt_reg;
   logic [2*nb-1:0]  result_reg;
   logic             tmo_reg;

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   logic [nb-1:0]    a_arr [NREQ];
   logic [nb-1:0]    b_arr [NREQ];
   logic             any_req;
   logic             wait_ready;
   logic             wait_expired;

   // Unpack the flat operand buses into per-requester slices.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign a_arr[gi] = a_in[gi*nb +: nb];
         assign b_arr[gi] = b_in[gi*nb +: nb];
      end
   endgenerate

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_reg),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign any_req      = |req;
   // Counter value zero marks the first WAIT cycle, where a ready left over
   // from an earlier (possibly aborted) operation must be ignored.
   assign wait_ready   = mul_ready && (cnt_reg != '0);
   assign wait_expired = (cnt_reg == CW'(TMO));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:  if (any_req) state_next = ST_START;
         ST_START: state_next = ST_WAIT;
         ST_WAIT:  if (wait_ready || wait_expired) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Grant capture, WAIT counter and result/timeout registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg    <= '0;
         owner_reg  <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
         tmo_reg    <= 1'b0;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (any_req) begin
                  owner_reg <= gnt_idx;
                  a_reg     <= a_arr[gnt_idx];
                  b_reg     <= b_arr[gnt_idx];
                  ptr_reg   <= IW'(wrap_inc(int'(gnt_idx), NREQ));
               end
            end
            ST_START: begin
               cnt_reg <= '0;
            end
            ST_WAIT: begin
               cnt_reg <= cnt_reg + CW'(1);
               if (wait_ready) begin
                  result_reg <= mul_product;
                  tmo_reg    <= 1'b0;
               end else if (wait_expired) begin
                  result_reg <= '0;
                  tmo_reg    <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode: ack in IDLE, start pulse, done to the owner, busy flag.
   always_comb begin
      ack       = '0;
      done      = '0;
      busy      = (state_reg != ST_IDLE);
      mul_start = (state_reg == ST_START);
      // ack is gated by rst_n so that it reads zero while reset is held.
      if (state_reg == ST_IDLE && rst_n) begin
         ack = gnt;
      end
      if (state_reg == ST_DONE) begin
         done[owner_reg] = 1'b1;
      end
   end

   assign mul_a  = a_reg;
   assign mul_b  = b_reg;
   assign result = result_reg;
   assign tmo    = tmo_reg;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Testbench for mult_share_ctrl: behavioural multiplier stub plus a
// transaction-level reference (round-robin pointer, signed 64-bit products).
module tb_mult_share_ctrl;

   localparam int NB   = 32;
   localparam int NREQ = 4;
   localparam int TMO  = NB + 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [NREQ-1:0]     req;
   logic [NREQ*NB-1:0]  a_in;
   logic [NREQ*NB-1:0]  b_in;
   logic [NREQ-1:0]     ack;
   logic [NREQ-1:0]     done;
   logic [2*NB-1:0]     result;
   logic                tmo;
   logic                busy;
   logic                mul_start;
   logic [NB-1:0]       mul_a;
   logic [NB-1:0]       mul_b;
   logic [2*NB-1:0]     mul_product;
   logic                mul_ready;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [NB-1:0]   opa [NREQ];
   logic [NB-1:0]   opb [NREQ];
   logic [NREQ-1:0] pend;
   int              ptr_m;
   logic [63:0]     last_res;
   logic            last_tmo;
   bit              noise_en;
   logic [63:0]     rr_exp [4];

   // Multiplier stub controls
   int          stub_lat = 1;
   bit          stub_never = 1'b0;
   bit          stub_stale = 1'b0;
   bit          stub_run = 1'b0;
   int          stub_rem = 0;
   logic [63:0] stub_pend = '0;
   logic [63:0] stub_prod = '0;

   always #5 clk = ~clk;

   mult_share_ctrl #(
      .nb   (NB),
      .NREQ (NREQ)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .a_in        (a_in),
      .b_in        (b_in),
      .ack         (ack),
      .done        (done),
      .result      (result),
      .tmo         (tmo),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .mul_ready   (mul_ready)
   );

   // Sequential multiplier stand-in: product appears stub_lat cycles after
   // the start is sampled; ready then stays high until the next start.
   always @(posedge clk) begin
      if (mul_start) begin
         stub_run  <= 1'b1;
         stub_rem  <= stub_lat;
         stub_pend <= longint'($signed(mul_a)) * longint'($signed(mul_b));
      end else if (stub_run && stub_rem > 0) begin
         stub_rem <= stub_rem - 1;
         if (stub_rem == 1) stub_prod <= stub_pend;
      end
   end

   assign mul_product = stub_prod;
   assign mul_ready   = stub_run && !stub_never &&
                        ((stub_rem == 0) || (stub_stale && stub_rem == stub_lat));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int pick_winner();
      for (int i = 0; i < NREQ; i++) begin
         int idx;
         idx = (ptr_m + i) % NREQ;
         if (pend[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < NREQ; i++) begin
         a_in[i*NB +: NB] = opa[i];
         b_in[i*NB +: NB] = opb[i];
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, 64'({mul_start, ack, done, busy, tmo}), 64'(0));
      check({tag, "_result"}, result, 64'(0));
      check({tag, "_ops"}, {mul_a, mul_b}, 64'(0));
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      req      = '0;
      pend     = '0;
      ptr_m    = 0;
      last_res = '0;
      last_tmo = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One arbitration slot starting at the IDLE cycle. Caller is positioned
   // just after a rising edge with the DUT in IDLE.
   task automatic run_op(input int lat, input bit nev, input bit stale, input bit hold,
                         input int abort_at, output int w, output logic [63:0] got);
      logic [NB-1:0] ea;
      logic [NB-1:0] eb;
      logic [63:0]   er;
      logic [63:0]   exp_res;
      int            waits;
      stub_lat   = lat;
      stub_never = nev;
      stub_stale = stale;
      req        = pend;
      drive_ops();
      got        = '0;
      @(negedge clk);
      w = pick_winner();
      check("idle_busy", 64'(busy), 64'(0));
      check("hold_result", result, last_res);
      check("hold_tmo", 64'(tmo), 64'(last_tmo));
      if (w < 0) begin
         check("idle_no_ack", 64'(ack), 64'(0));
         @(posedge clk);
         #1;
         return;
      end
      check("ack", 64'(ack), 64'(onehot(w)));
      ea    = opa[w];
      eb    = opb[w];
      er    = longint'($signed(ea)) * longint'($signed(eb));
      ptr_m = (w + 1) % NREQ;
      if (!hold) pend[w] = 1'b0;
      opa[w] = $urandom;
      opb[w] = $urandom;

      @(posedge clk);
      #1;
      req = noise_en ? NREQ'($urandom) : pend;
      drive_ops();
      @(negedge clk);
      check("start_ctl", 64'({mul_start, ack, done, busy}),
            64'({1'b1, {NREQ{1'b0}}, {NREQ{1'b0}}, 1'b1}));
      check("start_ops", {mul_a, mul_b}, {ea, eb});

      waits = nev ? TMO + 1 : lat + 1;
      for (int k = 1; k <= waits; k++) begin
         @(posedge clk);
         #1;
         if (noise_en) req = NREQ'($urandom);
         @(negedge clk);
         check("wait_ctl", 64'({mul_start, ack, done, busy}),
               64'({1'b0, {NREQ{1'b0}}, {NREQ{1'b0}}, 1'b1}));
         if (k == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            ptr_m    = 0;
            last_res = '0;
            last_tmo = 1'b0;
            req      = '0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            $display("op aborted: owner=%0d wait_cycle=%0d", w, k);
            return;
         end
      end

      @(posedge clk);
      #1;
      if (noise_en) req = NREQ'($urandom);
      @(negedge clk);
      exp_res = nev ? 64'(0) : er;
      check("done_ctl", 64'({done, ack, mul_start, busy}),
            64'({onehot(w), {NREQ{1'b0}}, 1'b0, 1'b1}));
      check("result", result, exp_res);
      check("tmo", 64'(tmo), 64'(nev));
      check("done_ops", {mul_a, mul_b}, {ea, eb});
      got      = result;
      last_res = exp_res;
      last_tmo = nev;
      $display("op: owner=%0d a=%h b=%h lat=%0d tmo=%0d result=%h", w, ea, eb, lat, tmo, result);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          w;
      logic [63:0] got;
      rr_exp[0] = 64'd6;
      rr_exp[1] = 64'd20;
      rr_exp[2] = 64'd42;
      rr_exp[3] = 64'd72;
      req      = '0;
      noise_en = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = '0;
         opb[i] = '0;
      end
      drive_ops();
      #1;
      do_reset();

      // Single requester, negative operand
      opa[0] = 32'hFFFF_FFFD;
      opb[0] = 32'd7;
      pend   = 4'b0001;
      run_op(3, 1'b0, 1'b0, 1'b0, 0, w, got);
      check("single_owner", 64'(w), 64'(0));
      check("single_res", got, 64'hFFFF_FFFF_FFFF_FFEB);

      // All four at once from a fresh pointer
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = NB'(2 * i + 2);
         opb[i] = NB'(2 * i + 3);
      end
      pend = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         run_op($urandom_range(1, 5), 1'b0, 1'b0, 1'b0, 0, w, got);
         check("rr_order", 64'(w), 64'(k));
         check("rr_res", got, rr_exp[k]);
      end

      // Fairness: requesters 0 and 2 held high continuously
      do_reset();
      pend = 4'b0101;
      for (int k = 0; k < 8; k++) begin
         run_op($urandom_range(1, 4), 1'b0, 1'b0, 1'b1, 0, w, got);
         check("fair_owner", 64'(w), 64'((k % 2) * 2));
      end

      // Operand extremes
      pend   = 4'b0100;
      opa[2] = 32'h8000_0000;
      opb[2] = 32'h8000_0000;
      run_op(2, 1'b0, 1'b0, 1'b0, 0, w, got);
      check("ext_minmin", got, 64'h4000_0000_0000_0000);
      pend   = 4'b1000;
      opa[3] = 32'h7FFF_FFFF;
      opb[3] = 32'hFFFF_FFFF;
      run_op(2, 1'b0, 1'b1, 1'b0, 0, w, got);
      check("ext_maxneg1", got, 64'hFFFF_FFFF_8000_0001);

      // Timeout: multiplier never ready
      pend = 4'b0010;
      run_op(1, 1'b1, 1'b0, 1'b0, 0, w, got);
      check("tmo_result", got, 64'(0));

      // Reset in WAIT cycle 10, then restart with the pointer back at 0
      pend = 4'b0100;
      run_op(5, 1'b1, 1'b0, 1'b0, 10, w, got);
      pend = 4'b1010;
      run_op(2, 1'b0, 1'b0, 1'b0, 0, w, got);
      check("post_rst_owner", 64'(w), 64'(1));

      // Randomised traffic with request noise while busy
      noise_en = 1'b1;
      for (int n = 0; n < 30; n++) begin
         if (pend == '0) pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         else if ($urandom_range(0, 1) == 1) pend = pend | NREQ'($urandom);
         if ($urandom_range(0, 9) == 0) pend = '0;
         run_op($urandom_range(1, 6), ($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0, w, got);
      end
      noise_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
